// File: rtl/axi_w_req_arbiter_if.sv
// Link between the write-request arbiter and the single burst write master.
// The arbiter uses the master modport; the burst engine (or a bench) uses slave.
interface axi_w_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  m_wen;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [3:0]            m_awlen;
    logic [2:0]            m_awsize;
    logic [ID_WIDTH-1:0]   m_awid;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [3:0]            m_wmask;
    logic                  m_data_resp;
    logic [3:0]            m_wdata_ptr;
    logic                  m_waddr_ok;
    logic                  m_wdata_ok;

    modport master (
        output m_wen, m_awaddr, m_awlen, m_awsize, m_awid, m_wdata, m_wmask, m_data_resp,
        input  m_wdata_ptr, m_waddr_ok, m_wdata_ok
    );

    modport slave (
        input  m_wen, m_awaddr, m_awlen, m_awsize, m_awid, m_wdata, m_wmask, m_data_resp,
        output m_wdata_ptr, m_waddr_ok, m_wdata_ok
    );
endinterface

// File: rtl/axi_w_req_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI burst write master,
// with a sticky watchdog on the outstanding write.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_w_req_arbiter #(
    parameter int DATA_WIDTH     = `AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH     = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH       = `AXI_ID_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  s0_req,
    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [3:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [ID_WIDTH-1:0]   s0_awid,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic [3:0]            s0_wmask,
    input  logic                  s0_data_resp,
    output logic                  s0_gnt,
    output logic [3:0]            s0_wdata_ptr,
    output logic                  s0_done,
    input  logic                  s1_req,
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [3:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [ID_WIDTH-1:0]   s1_awid,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [3:0]            s1_wmask,
    input  logic                  s1_data_resp,
    output logic                  s1_gnt,
    output logic [3:0]            s1_wdata_ptr,
    output logic                  s1_done,
    axi_w_req_arbiter_if.master   m,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;   // 0 = s0 owns the master, 1 = s1
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            wen, done0, done1, active;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        wen     = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_req || s1_req) begin
                    state_d = ISSUE;
                    sel_d   = (s0_req && s1_req) ? rr_q : s1_req;
                end
            end
            ISSUE: begin
                wen = 1'b1;
                if (m.m_waddr_ok) state_d = BUSY;
            end
            BUSY: begin
                if (m.m_wdata_ok) begin
                    state_d = IDLE;
                    rr_d    = ~sel_q;
                    done0   = ~sel_q;
                    done1   = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog only observes; it never forces the FSM out of a stuck write.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (state_d == ISSUE) cnt_q <= '0;
        end else begin
            if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
        end
    end

    assign active = (state_q != IDLE);

    // Every master-side field is forced to 0 in IDLE so reset leaves all outputs low.
    assign m.m_wen       = wen;
    assign m.m_awaddr    = !active ? '0 : (sel_q ? s1_awaddr    : s0_awaddr);
    assign m.m_awlen     = !active ? '0 : (sel_q ? s1_awlen     : s0_awlen);
    assign m.m_awsize    = !active ? '0 : (sel_q ? s1_awsize    : s0_awsize);
    assign m.m_awid      = !active ? '0 : (sel_q ? s1_awid      : s0_awid);
    assign m.m_wdata     = !active ? '0 : (sel_q ? s1_wdata     : s0_wdata);
    assign m.m_wmask     = !active ? '0 : (sel_q ? s1_wmask     : s0_wmask);
    assign m.m_data_resp = !active ? '0 : (sel_q ? s1_data_resp : s0_data_resp);

    assign s0_gnt       = active && !sel_q;
    assign s1_gnt       = active &&  sel_q;
    assign s0_wdata_ptr = s0_gnt ? m.m_wdata_ptr : 4'd0;
    assign s1_wdata_ptr = s1_gnt ? m.m_wdata_ptr : 4'd0;
    assign s0_done      = done0;
    assign s1_done      = done1;
    assign busy         = active;
    assign timeout_err  = err_q;
endmodule

// File: doc/axi_w_req_arbiter.md
AXI_W_REQ_ARBITER -- requirements
Module: axi_w_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `AXI_ADDR_WIDTH, address width.
REQ-003 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH, AXI ID width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit for an outstanding write.
REQ-005 SHALL have ports:
- ACLK  in  1  clock. One clock only: all state changes on ACLK rising edge.
- ARESETn  in  1  reset. Asynchronous, active-low.
- sN_req  in  1  requester N write request (N=0,1); level signal.
- sN_awaddr  in  ADDR_WIDTH  requester N address.
- sN_awlen  in  4  requester N burst length minus 1.
- sN_awsize  in  3  requester N beat size.
- sN_awid  in  ID_WIDTH  requester N ID.
- sN_wdata  in  DATA_WIDTH  requester N data.
- sN_wmask  in  4  requester N byte mask.
- sN_data_resp  in  1  requester N ready to accept B response.
- sN_gnt  out  1  requester N owns the write master.
- sN_wdata_ptr  out  4  beat index returned to requester N.
- sN_done  out  1  one-cycle completion pulse to requester N.
- m_wen, m_awaddr, m_awlen, m_awsize, m_awid, m_wdata, m_wmask, m_data_resp  out  (widths as sN_*)  request to the burst write master.
- m_wdata_ptr  in  4  master beat index.
- m_waddr_ok  in  1  master idle / able to capture.
- m_wdata_ok  in  1  master one-cycle write-complete pulse.
- busy  out  1  arbiter not idle.
- timeout_err  out  1  sticky watchdog flag.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, BUSY.
REQ-007 In IDLE with any sN_req=1, the arbiter SHALL register the grant and enter ISSUE; sN_gnt SHALL rise on the next cycle.
REQ-008 If only one requester requests, it SHALL win.
REQ-009 If both request, the requester selected by the round-robin pointer rr SHALL win; rr resets to 0 (s0 first).
REQ-010 rr SHALL flip to the non-served requester on each completion.
REQ-011 In ISSUE, m_wen SHALL be 1, with all m_* fields combinationally muxed from the granted requester.
REQ-012 In ISSUE, when m_waddr_ok=1 the FSM SHALL move to BUSY on the next cycle; otherwise it SHALL hold ISSUE with m_wen=1.
REQ-013 In BUSY, m_wen SHALL be 0; fields SHALL remain muxed from the granted requester.
REQ-014 m_data_resp SHALL equal the granted requester's sN_data_resp in ISSUE and BUSY, and 0 in IDLE.
REQ-015 sN_wdata_ptr SHALL equal m_wdata_ptr while sN_gnt=1, else 0.
REQ-016 In BUSY, m_wdata_ok=1 SHALL cause a one-cycle sN_done pulse for the granted requester in the same cycle.
REQ-017 On the cycle after an m_wdata_ok completion, the FSM SHALL be in IDLE and sN_gnt SHALL be 0.
REQ-018 A request asserted during the completion cycle SHALL be arbitrated in IDLE; there SHALL be a minimum of one IDLE cycle between grants.
REQ-019 Requesters SHALL hold sN_req and all fields stable until sN_done.
REQ-020 sN_req dropping while granted SHALL be ignored; the transaction SHALL run to completion.
REQ-021 m_wdata_ok outside BUSY SHALL be ignored.
REQ-022 The watchdog counter SHALL clear on entering ISSUE and increment each ISSUE/BUSY cycle, saturating at TIMEOUT_CYCLES.
REQ-023 On reaching TIMEOUT_CYCLES, timeout_err SHALL set and stay set until reset; the FSM state SHALL be unaffected.
REQ-024 busy SHALL be 1 in ISSUE and BUSY.
REQ-025 At most one sN_gnt SHALL be high at any time.

Reset
REQ-026 ARESETn=0 SHALL immediately force: FSM to IDLE, rr=0, watchdog counter 0, timeout_err 0.
REQ-027 During reset, all outputs SHALL be 0.
REQ-028 Reset mid-transaction SHALL drop the grant with no sN_done pulse.

Verification
REQ-029 s0_req only, awaddr 0x100, awlen 3, master idle -> s0_gnt and m_wen rise 1 cycle later; m_awaddr=0x100; m_wen drops after m_waddr_ok; s0_done pulses with m_wdata_ok.
REQ-030 s0_req and s1_req together from reset -> s0 served first, then s1 with exactly one IDLE cycle between grants; s1_gnt never overlaps s0_gnt.
REQ-031 s1 re-requests immediately after its done while s0 waits -> s0 wins the next grant.
REQ-032 m_waddr_ok held 0 for 5 cycles in ISSUE -> m_wen stays 1 for all 5 cycles; BUSY is entered on the cycle after m_waddr_ok=1.
REQ-033 TIMEOUT_CYCLES=16 with m_wdata_ok withheld -> timeout_err=1 after 16 cycles; a later m_wdata_ok still produces done and the FSM returns to IDLE.
REQ-034 ARESETn pulsed low in BUSY -> all outputs 0 asynchronously; no done pulse; after release, a pending request is granted with rr=0.
